// File: rtl/mdu_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mdu_ctrl_pkg
//  Description : MD operation codes and controller state encodings.
//  Revision    : 1.0 - initial release
// ============================================================================
package mdu_ctrl_pkg;

    localparam logic [3:0] c_MD_NONE  = 4'd0;
    localparam logic [3:0] c_MD_MULT  = 4'd1;
    localparam logic [3:0] c_MD_MULTU = 4'd2;
    localparam logic [3:0] c_MD_DIV   = 4'd3;
    localparam logic [3:0] c_MD_DIVU  = 4'd4;
    localparam logic [3:0] c_MD_MFHI  = 4'd5;
    localparam logic [3:0] c_MD_MFLO  = 4'd6;
    localparam logic [3:0] c_MD_MTHI  = 4'd7;
    localparam logic [3:0] c_MD_MTLO  = 4'd8;

    localparam logic [0:0] c_ST_IDLE  = 1'b0;
    localparam logic [0:0] c_ST_RUN   = 1'b1;

endpackage
`default_nettype wire

// File: rtl/md_arith.sv
`default_nettype none
// ============================================================================
//  Module      : md_arith
//  Description : Combinational mult/div datapath producing {hi,lo} and div0.
//  Revision    : 1.0 - initial release
// ============================================================================
module md_arith
    import mdu_ctrl_pkg::*;
(
    input  logic [3:0]  i_op,
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    output logic [63:0] o_result,
    output logic        o_div0
);

    logic [63:0] w_sa;
    logic [63:0] w_sb;
    logic [63:0] w_smul;
    logic [63:0] w_umul;
    logic        w_bzero;
    logic        w_ovf;
    logic [31:0] w_ubs;
    logic [31:0] w_sbs;
    logic [31:0] w_uq;
    logic [31:0] w_ur;
    logic [31:0] w_sq;
    logic [31:0] w_sr;

    assign w_sa   = {{32{i_a[31]}}, i_a};
    assign w_sb   = {{32{i_b[31]}}, i_b};
    assign w_smul = w_sa * w_sb;
    assign w_umul = {32'd0, i_a} * {32'd0, i_b};

    // Substituting a divisor of 1 avoids x/0 and makes the overflow case
    // naturally yield quotient 0x80000000, remainder 0.
    assign w_bzero = (i_b == 32'd0);
    assign w_ovf   = (i_a == 32'h8000_0000) && (i_b == 32'hFFFF_FFFF);
    assign w_ubs   = w_bzero ? 32'd1 : i_b;
    assign w_sbs   = (w_bzero || w_ovf) ? 32'd1 : i_b;
    assign w_uq    = i_a / w_ubs;
    assign w_ur    = i_a % w_ubs;
    assign w_sq    = $signed(i_a) / $signed(w_sbs);
    assign w_sr    = $signed(i_a) % $signed(w_sbs);

    always_comb begin
        o_result = 64'd0;
        o_div0   = 1'b0;
        case (i_op)
            c_MD_MULT:  o_result = w_smul;
            c_MD_MULTU: o_result = w_umul;
            c_MD_DIV: begin
                o_result = {w_sr, w_sq};
                o_div0   = w_bzero;
            end
            c_MD_DIVU: begin
                o_result = {w_ur, w_uq};
                o_div0   = w_bzero;
            end
            default: o_result = 64'd0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mdu_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : mdu_ctrl
//  Description : E-stage multi-cycle mult/div controller owning HI/LO.
//  Revision    : 1.0 - initial release
// ============================================================================
module mdu_ctrl
    import mdu_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  md_op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        req,
    input  logic        md_use_d,
    output logic        busy,
    output logic        stall_md,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] rd_data
);

    logic [0:0]  r_state, w_state_nxt;
    logic [3:0]  r_cnt,   w_cnt_nxt;
    logic [31:0] r_phi,   w_phi_nxt;
    logic [31:0] r_plo,   w_plo_nxt;
    logic        r_pdiv0, w_pdiv0_nxt;
    logic [31:0] r_hi,    w_hi_nxt;
    logic [31:0] r_lo,    w_lo_nxt;

    logic [63:0] w_result;
    logic        w_div0;
    logic        w_is_mult;
    logic        w_is_md;
    logic        w_start;

    md_arith u_arith (
        .i_op     (md_op),
        .i_a      (a),
        .i_b      (b),
        .o_result (w_result),
        .o_div0   (w_div0)
    );

    assign w_is_mult = (md_op == c_MD_MULT) || (md_op == c_MD_MULTU);
    assign w_is_md   = w_is_mult || (md_op == c_MD_DIV) || (md_op == c_MD_DIVU);
    assign w_start   = w_is_md && !req && (r_state == c_ST_IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_ST_IDLE;
            r_cnt   <= 4'd0;
            r_phi   <= 32'd0;
            r_plo   <= 32'd0;
            r_pdiv0 <= 1'b0;
            r_hi    <= 32'd0;
            r_lo    <= 32'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_phi   <= w_phi_nxt;
            r_plo   <= w_plo_nxt;
            r_pdiv0 <= w_pdiv0_nxt;
            r_hi    <= w_hi_nxt;
            r_lo    <= w_lo_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_phi_nxt   = r_phi;
        w_plo_nxt   = r_plo;
        w_pdiv0_nxt = r_pdiv0;
        w_hi_nxt    = r_hi;
        w_lo_nxt    = r_lo;
        case (r_state)
            c_ST_IDLE: begin
                if (w_start) begin
                    w_state_nxt = c_ST_RUN;
                    w_cnt_nxt   = w_is_mult ? 4'(MULT_CYCLES) : 4'(DIV_CYCLES);
                    w_phi_nxt   = w_result[63:32];
                    w_plo_nxt   = w_result[31:0];
                    w_pdiv0_nxt = w_div0;
                end else if (!req) begin
                    if (md_op == c_MD_MTHI) w_hi_nxt = a;
                    if (md_op == c_MD_MTLO) w_lo_nxt = a;
                end
            end
            default: begin
                // Ops arriving in E while running are ignored; the stall prevents them.
                if (r_cnt == 4'd1) begin
                    w_state_nxt = c_ST_IDLE;
                    w_cnt_nxt   = 4'd0;
                    if (!r_pdiv0) begin
                        w_hi_nxt = r_phi;
                        w_lo_nxt = r_plo;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
        endcase
    end

    assign busy     = (r_state == c_ST_RUN);
    assign stall_md = md_use_d && (busy || w_start);
    assign hi       = r_hi;
    assign lo       = r_lo;
    assign rd_data  = (md_op == c_MD_MFHI) ? r_hi :
                      (md_op == c_MD_MFLO) ? r_lo : 32'd0;

endmodule
`default_nettype wire

// File: tb/tb_mdu_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mdu_ctrl
//  Description : Scoreboard bench for mdu_ctrl with directed mult/div vectors.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mdu_ctrl;
    import mdu_ctrl_pkg::*;

    logic        clk;
    logic        reset;
    logic [3:0]  md_op;
    logic [31:0] a;
    logic [31:0] b;
    logic        req;
    logic        md_use_d;
    logic        busy;
    logic        stall_md;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] rd_data;

    int          n_pass  = 0;
    int          n_total = 0;
    logic [63:0] sb_q[$];
    logic        r_prev_busy = 1'b0;

    mdu_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk      (clk),
        .reset    (reset),
        .md_op    (md_op),
        .a        (a),
        .b        (b),
        .req      (req),
        .md_use_d (md_use_d),
        .busy     (busy),
        .stall_md (stall_md),
        .hi       (hi),
        .lo       (lo),
        .rd_data  (rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Result monitor: every busy 1->0 transition retires the oldest expected {hi,lo}.
    always @(negedge clk) begin
        if (r_prev_busy && !busy && sb_q.size() > 0) begin
            logic [63:0] w_exp;
            w_exp = sb_q.pop_front();
            chk("retire hi/lo", {hi, lo}, w_exp);
        end
        r_prev_busy = busy;
    end

    always @(posedge clk) begin
        if (!reset && busy && md_op != c_MD_NONE) begin
            n_total++;
            $display("FAIL illegal op while busy: got op %0d expected %0d", md_op, c_MD_NONE);
        end
    end

    task automatic run_op(input string name, input logic [3:0] op, input logic [31:0] av,
                          input logic [31:0] bv, input logic use_d, input int exp_cycles,
                          input logic [63:0] exp_res, input int req_at);
        int n;
        @(negedge clk);
        md_op = op; a = av; b = bv; md_use_d = use_d;
        sb_q.push_back(exp_res);
        #1 chk({name, " stall at start"}, {63'd0, stall_md}, {63'd0, use_d});
        @(negedge clk);
        md_op = c_MD_NONE;
        n = 0;
        while (busy && n < 40) begin
            req = (n == req_at);
            #1 chk({name, " stall while busy"}, {63'd0, stall_md}, {63'd0, use_d});
            n++;
            @(negedge clk);
        end
        req = 1'b0;
        #1;
        chk({name, " busy cycles"}, 64'(n), 64'(exp_cycles));
        chk({name, " stall after"}, {63'd0, stall_md}, 64'd0);
        md_use_d = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; md_op = c_MD_NONE; a = '0; b = '0; req = 1'b0; md_use_d = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset busy",  {63'd0, busy}, 64'd0);
        chk("reset hi/lo", {hi, lo}, 64'd0);
        chk("reset stall", {63'd0, stall_md}, 64'd0);
        reset = 1'b0;
        md_use_d = 1'b0;

        run_op("mult -3*5", c_MD_MULT, 32'hFFFF_FFFD, 32'd5, 1'b1, 5,
               {32'hFFFF_FFFF, 32'hFFFF_FFF1}, -1);
        @(negedge clk);
        md_op = c_MD_MFHI; #1 chk("mfhi rd_data", {32'd0, rd_data}, {32'd0, 32'hFFFF_FFFF});
        md_op = c_MD_MFLO; #1 chk("mflo rd_data", {32'd0, rd_data}, {32'd0, 32'hFFFF_FFF1});
        md_op = c_MD_NONE; #1 chk("none rd_data", {32'd0, rd_data}, 64'd0);

        run_op("multu", c_MD_MULTU, 32'hFFFF_FFFD, 32'd5, 1'b0, 5,
               {32'h0000_0004, 32'hFFFF_FFF1}, -1);
        run_op("div -7/2", c_MD_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0, 10,
               {32'hFFFF_FFFF, 32'hFFFF_FFFD}, -1);
        run_op("divu 7/2", c_MD_DIVU, 32'd7, 32'd2, 1'b1, 10,
               {32'd1, 32'd3}, -1);
        run_op("div ovf", c_MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 10,
               {32'd0, 32'h8000_0000}, -1);

        @(negedge clk);
        md_op = c_MD_MTHI; a = 32'h0000_1234;
        @(negedge clk);
        md_op = c_MD_NONE;
        #1 chk("mthi hi/lo", {hi, lo}, {32'h0000_1234, 32'h8000_0000});

        run_op("divu by 0", c_MD_DIVU, 32'd5, 32'd0, 1'b0, 10,
               {32'h0000_1234, 32'h8000_0000}, -1);

        @(negedge clk);
        md_op = c_MD_MULT; a = 32'd2; b = 32'd3; req = 1'b1; md_use_d = 1'b1;
        #1 chk("req mult stall", {63'd0, stall_md}, 64'd0);
        @(negedge clk);
        chk("req mult busy", {63'd0, busy}, 64'd0);
        md_op = c_MD_MTLO; a = 32'h55;
        @(negedge clk);
        md_op = c_MD_NONE; req = 1'b0; md_use_d = 1'b0;
        chk("req busy", {63'd0, busy}, 64'd0);
        chk("req hi/lo", {hi, lo}, {32'h0000_1234, 32'h8000_0000});

        run_op("mult req in run", c_MD_MULT, 32'd2, 32'd3, 1'b0, 5, {32'd0, 32'd6}, 2);

        @(negedge clk);
        md_op = c_MD_DIV; a = 32'd100; b = 32'd7;
        @(negedge clk);
        md_op = c_MD_NONE;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("mid-op reset busy",  {63'd0, busy}, 64'd0);
        chk("mid-op reset hi/lo", {hi, lo}, 64'd0);
        reset = 1'b0;
        repeat (12) @(negedge clk);
        chk("abandoned hi/lo", {hi, lo}, 64'd0);
        chk("abandoned busy", {63'd0, busy}, 64'd0);

        @(negedge clk);
        chk("scoreboard drained", 64'(sb_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mdu_ctrl.md
Name: mdu_ctrl

Overview:
- Multi-cycle multiply/divide unit controller in the E stage of the 5-stage MIPS pipeline.
- Decodes the MD-class instruction in E, sequences a fixed-latency mult/div, owns the HI/LO registers and serves mfhi/mflo reads.
- Raises the D-stage stall request that the hazard unit ORs into its stall.
- Honours the CP0 exception request so that a cancelled instruction never alters HI/LO.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (legal range 1..15).
- DIV_CYCLES, 10, busy cycles for div/divu (legal range 1..15).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- md_op  in  4  MD operation of the instruction currently in E (`MD_NONE when none).
- a  in  32  rs operand (forwarded value).
- b  in  32  rt operand (forwarded value).
- req  in  1  exception/interrupt request from CP0; cancels the E-stage MD op this cycle.
- md_use_d  in  1  instruction in D is MD-class (mult/div/mfhi/mflo/mthi/mtlo).
- busy  out  1  mult/div in flight.
- stall_md  out  1  stall request for D.
- hi  out  32  HI register.
- lo  out  32  LO register.
- rd_data  out  32  mfhi -> hi, mflo -> lo, otherwise 0.

Behaviour:
- Reset (sync, active-high) wins over everything. State=IDLE, cnt=0, hi=lo=0, busy=0, pending result cleared. Applies mid-operation as well: the in-flight op is abandoned.
- Registered state: two states, IDLE and RUN. A 4-bit down-counter cnt and 64-bit pending result {phi,plo}.
- start = (md_op is MULT/MULTU/DIV/DIVU) & !req & (state==IDLE).
- IDLE->RUN on start at edge T:
  - Load cnt = MULT_CYCLES or DIV_CYCLES.
  - Compute the result at that edge and capture it into {phi,plo}.
  - busy=1 from T+1.
- RUN:
  - Decrement cnt each edge.
  - On the edge where cnt==1, write hi<=phi, lo<=plo, return to IDLE; busy=0 in the same cycle the new HI/LO are visible.
  - A start issued at T gives busy high for exactly N cycles, and new HI/LO are visible at T+N+1.
- Arithmetic:
  - mult: signed 32x32->64, {hi,lo}=product.
  - multu: unsigned 32x32->64, {hi,lo}=product.
  - div: lo=quotient truncated toward zero, hi=remainder with the sign of the dividend.
  - divu: unsigned, lo=quotient, hi=remainder.
  - Signed overflow 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
  - Divide by zero (b==0, div or divu): the operation still occupies DIV_CYCLES, but HI/LO keep their old values.
- mthi/mtlo: hi<=a or lo<=a at the edge when md_op matches, !req and state==IDLE. Ignored while busy; this cannot occur legally because of stall_md.
- MD op arriving while busy (illegal, prevented by stall) is ignored. The bench flags it.
- req=1: the E-stage md_op is fully ignored (no start, no mthi/mtlo). An op already in RUN continues to completion, because it belongs to an older, committed instruction.
- stall_md = md_use_d & (busy | start). This is combinational.
- rd_data is combinational from the current hi/lo and does not depend on busy. The stall guarantees mfhi/mflo never reach E while busy.

Decomposition:
- constants.v gains the MD op codes:
  - `MD_NONE=0, `MD_MULT=1, `MD_MULTU=2, `MD_DIV=3, `MD_DIVU=4
  - `MD_MFHI=5, `MD_MFLO=6, `MD_MTHI=7, `MD_MTLO=8
  - RUN/IDLE state codes.
- CU decodes mult/div/mfhi/mflo/mthi/mtlo into md_op and md_use.
- One natural sub-module: md_arith, purely combinational (op, a, b -> 64-bit result, div0 flag). The controller holds all state.

Test Plan:
- mult a=0xFFFFFFFD (-3), b=5 at edge T -> busy high T+1..T+5; hi=0xFFFFFFFF, lo=0xFFFFFFF1 at T+6; multu with the same operands -> hi=0x00000004, lo=0xFFFFFFF1.
- div a=0xFFFFFFF9 (-7), b=2 -> after 10 busy cycles lo=0xFFFFFFFD, hi=0xFFFFFFFF; divu 7/2 -> lo=3, hi=1; div 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- mthi a=0x1234 then divu b=0 -> busy for 10 cycles, afterwards hi=0x1234 and lo unchanged.
- Stall: mult starts with md_use_d=1 -> stall_md=1 in the start cycle and through all 5 busy cycles, 0 after; with md_use_d=0, stall_md=0 throughout.
- req=1 coincident with a mult op or an mtlo op -> busy stays 0 and hi/lo unchanged; req=1 during RUN -> the op still completes and writes HI/LO.
- reset asserted at busy cycle 3 of a div -> next cycle busy=0, hi=lo=0, and the pending result is never written.
